// File: rtl/fir_serial_pkg.sv
// fir_serial_pkg
// Types and constants shared by the bit-serial link blocks of the FIR filter
// (serializer and deserializer).
//   state_e        : 2-bit FSM encoding, identical across serializer/deserializer
//   DEFAULT_LENGTH : default parallel word width
//   cnt_width()    : width of a bit counter that must hold the value len
package fir_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_HOLD  = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_LENGTH = 24;

    // Counter has to reach len itself, hence len+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/deserializer_fsm.sv
// deserializer_fsm
// Collects LENGTH serial bits (LSB first) under a valid/ready handshake and
// presents them as one parallel word under a second valid/ready handshake.
// All outputs are registered; i_en gates every register except reset.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous active-low reset (overrides i_en)
//   i_en         : clock enable; low freezes all state
//   i_din        : serial data bit
//   i_din_valid  : i_din carries a valid bit
//   o_ready      : ready to accept a serial bit (high exactly in S_SHIFT)
//   ov_dout      : assembled parallel word, first bit received in bit 0
//   o_dout_valid : ov_dout holds a complete word
//   i_ready      : downstream accepts ov_dout (only looked at in S_HOLD)
module deserializer_fsm
    import fir_serial_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready
);

    localparam int unsigned   CNT_W    = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

    state_e              state_q, state_d;
    logic [LENGTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LENGTH-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                ready_q, ready_d;

    logic [LENGTH-1:0]   sr_shifted;
    logic                bit_xfer;
    logic                word_xfer;

    // New bits enter at the MSB and move down, so after LENGTH shifts the
    // first bit received sits in bit 0.
    assign sr_shifted = {i_din, sr_q[LENGTH-1:1]};
    assign bit_xfer   = ready_q && i_din_valid;
    assign word_xfer  = dout_valid_q && i_ready;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ready_d      = ready_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
                sr_d    = '0;
                ready_d = 1'b1;
            end

            S_SHIFT: begin
                if (bit_xfer) begin
                    sr_d = sr_shifted;
                    if (cnt_q == CNT_LAST) begin
                        dout_d       = sr_shifted;
                        dout_valid_d = 1'b1;
                        ready_d      = 1'b0;
                        cnt_d        = '0;
                        state_d      = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_HOLD: begin
                // Serial input is ignored here; ov_dout stays put until taken.
                if (word_xfer) begin
                    dout_valid_d = 1'b0;
                    ready_d      = 1'b1;
                    sr_d         = '0;
                    state_d      = S_SHIFT;
                end
            end

            default: begin
                state_d      = S_IDLE;
                ready_d      = 1'b0;
                dout_valid_d = 1'b0;
                cnt_d        = '0;
                sr_d         = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else if (i_en) begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready      = ready_q;
    assign ov_dout      = dout_q;
    assign o_dout_valid = dout_valid_q;

endmodule

// File: tb/tb_deserializer_fsm.sv
// tb_deserializer_fsm
// Directed self-checking bench for deserializer_fsm (LENGTH = 24), finishing
// with a loopback run against a behavioural serializer model.
module tb_deserializer_fsm;

    localparam int unsigned LEN = 24;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           din;
    logic           din_valid;
    logic           ready_o;
    logic [LEN-1:0] dout;
    logic           dout_valid;
    logic           ready_i;

    int n_checks = 0;
    int n_errors = 0;

    deserializer_fsm #(
        .LENGTH(LEN)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_din       (din),
        .i_din_valid (din_valid),
        .o_ready     (ready_o),
        .ov_dout     (dout),
        .o_dout_valid(dout_valid),
        .i_ready     (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the 24 bits of w LSB first. gap_after[i] inserts 3 idle cycles
    // after bit i (not after the last bit). pause_after >= 0 drops i_en for
    // 5 cycles after that bit while offering a wrong bit with valid high.
    // cycles counts enabled cycles from the first bit to word completion.
    task automatic send_word(input logic [LEN-1:0] w, input logic [LEN-1:0] gap_after,
                             input int pause_after, output int cycles);
        cycles = 0;
        for (int i = 0; i < LEN; i++) begin
            din_valid = 1'b1;
            din       = w[i];
            step();
            cycles++;
            if (gap_after[i] && i < LEN - 1) begin
                din_valid = 1'b0;
                din       = ~w[i];
                repeat (3) step();
                cycles += 3;
            end
            if (i == pause_after && i < LEN - 1) begin
                en        = 1'b0;
                din_valid = 1'b1;
                din       = ~w[i+1];
                repeat (5) step();
                check_eq("en_pause_ready", 32'(ready_o), 32'd1);
                check_eq("en_pause_valid", 32'(dout_valid), 32'd0);
                en = 1'b1;
            end
        end
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    int             cyc;
    logic [LEN-1:0] held;
    logic [LEN-1:0] exp_q[$];
    logic [LEN-1:0] cur;
    int             bit_idx;
    int             sent;
    int             got;
    logic           xfer;
    logic [LEN-1:0] exp_w;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        ready_i   = 1'b0;
        repeat (2) step();

        // Reset state
        check_eq("rst_ready", 32'(ready_o), 32'd0);
        check_eq("rst_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);

        rst_n = 1'b1;
        step();
        check_eq("first_ready", 32'(ready_o), 32'd1);

        // Gap-free word
        ready_i = 1'b1;
        send_word(24'hA5C3F0, 24'h0, -1, cyc);
        check_eq("w1_cycles", 32'(cyc), 32'd24);
        check_eq("w1_valid", 32'(dout_valid), 32'd1);
        check_eq("w1_dout", 32'(dout), 32'h00A5C3F0);
        check_eq("w1_ready_hold", 32'(ready_o), 32'd0);
        step();
        check_eq("w1_valid_one_cycle", 32'(dout_valid), 32'd0);
        check_eq("w1_ready_again", 32'(ready_o), 32'd1);

        // Bubbles after bits 0, 11 and 22: 9 extra cycles
        send_word(24'h000001, 24'h400801, -1, cyc);
        check_eq("gap_cycles", 32'(cyc), 32'd33);
        check_eq("gap_valid", 32'(dout_valid), 32'd1);
        check_eq("gap_dout", 32'(dout), 32'h00000001);
        step();
        check_eq("gap_accept", 32'(ready_o), 32'd1);

        // Backpressure with serial traffic offered
        ready_i = 1'b0;
        send_word(24'h5A5A5A, 24'h0, -1, cyc);
        check_eq("bp_valid", 32'(dout_valid), 32'd1);
        held = dout;
        check_eq("bp_dout", 32'(held), 32'h005A5A5A);
        for (int k = 0; k < 10; k++) begin
            din_valid = 1'b1;
            din       = 1'($urandom_range(0, 1));
            step();
            check_eq("bp_dout_stable", 32'(dout), 32'h005A5A5A);
            check_eq("bp_ready_low", 32'(ready_o), 32'd0);
        end
        check_eq("bp_valid_held", 32'(dout_valid), 32'd1);
        din_valid = 1'b0;
        ready_i   = 1'b1;
        step();
        check_eq("bp_release_ready", 32'(ready_o), 32'd1);
        check_eq("bp_release_valid", 32'(dout_valid), 32'd0);
        send_word(24'hFFFFFF, 24'h0, -1, cyc);
        check_eq("bp_next_cycles", 32'(cyc), 32'd24);
        check_eq("bp_next_dout", 32'(dout), 32'h00FFFFFF);
        step();

        // Reset mid-word discards the partial word
        for (int i = 0; i < 12; i++) begin
            din_valid = 1'b1;
            din       = cur[0];
            cur       = 24'h123456;
            din       = cur[i];
            step();
        end
        din_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        check_eq("mrst_ready", 32'(ready_o), 32'd0);
        check_eq("mrst_valid", 32'(dout_valid), 32'd0);
        check_eq("mrst_dout", 32'(dout), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("mrst_ready_back", 32'(ready_o), 32'd1);
        send_word(24'h654321, 24'h0, -1, cyc);
        check_eq("mrst_cycles", 32'(cyc), 32'd24);
        check_eq("mrst_dout_new", 32'(dout), 32'h00654321);
        step();

        // Clock enable low mid-word and in S_HOLD
        send_word(24'h800001, 24'h0, 7, cyc);
        check_eq("en_cycles", 32'(cyc), 32'd24);
        check_eq("en_valid", 32'(dout_valid), 32'd1);
        check_eq("en_dout", 32'(dout), 32'h00800001);
        en = 1'b0;
        repeat (5) step();
        check_eq("en_hold_valid", 32'(dout_valid), 32'd1);
        check_eq("en_hold_ready", 32'(ready_o), 32'd0);
        en = 1'b1;
        step();
        check_eq("en_accept_valid", 32'(dout_valid), 32'd0);
        check_eq("en_accept_ready", 32'(ready_o), 32'd1);

        // Loopback: serializer model with random bubbles, random consumer stalls
        sent    = 0;
        got     = 0;
        bit_idx = 0;
        cur     = LEN'($urandom);
        for (int c = 0; c < 20000 && got < 100; c++) begin
            din_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            din       = cur[bit_idx];
            ready_i   = 1'($urandom_range(0, 1));
            xfer      = ready_o && din_valid;
            if (dout_valid && ready_i) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : ~dout;
                check_eq("loop_word", 32'(dout), 32'(exp_w));
                got++;
            end
            step();
            if (xfer) begin
                if (bit_idx == LEN - 1) begin
                    exp_q.push_back(cur);
                    sent++;
                    cur     = LEN'($urandom);
                    bit_idx = 0;
                end else begin
                    bit_idx++;
                end
            end
        end
        din_valid = 1'b0;
        check_eq("loop_count", 32'(got), 32'd100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
